// File: rtl/ruleid_loader.sv
// Status-bus loader: builds 512-bit rule beats from 32-bit writes; requests commit one cycle after entry, reads pulse the cycle after.
// Backpressure: out_ready stalls the output FIFO; pushes into a full FIFO are dropped and counted.
module ruleid_fifo #(
   parameter int W     = 512,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   output logic          push_rdy,
   input  logic          pop_rdy,
   output logic          head_vld,
   output logic [W-1:0]  head_dat,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);
   localparam int AW = LW - 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push;
   logic          pop;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign head_vld = !empty;
   assign head_dat = head_vld ? mem[rd_ptr] : '0;
   assign pop      = head_vld & pop_rdy;
   // A pop in the same cycle frees the slot the push lands in.
   assign push_rdy = !full | pop;
   assign push     = push_vld & push_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end
endmodule

module ruleid_loader #(
   parameter int                     STAT_AWIDTH = 4,
   parameter logic [STAT_AWIDTH-1:0] SEL_VALUE   = 4'd9,
   parameter int                     FIFO_DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [29:0]  status_addr,
   input  logic         status_read,
   input  logic         status_write,
   input  logic [31:0]  status_writedata,
   output logic [31:0]  status_readdata,
   output logic         status_readdata_valid,
   output logic [511:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [STAT_AWIDTH-1:0] sel_q;
   logic [4:0]             off_q;
   logic                   rd_q;
   logic                   wr_q;
   logic [31:0]            wdat_q;
   logic                   addr_unused;

   assign addr_unused = ^status_addr[29-STAT_AWIDTH:5];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q  <= '0;
         off_q  <= '0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         wdat_q <= '0;
      end else begin
         sel_q  <= status_addr[29:30-STAT_AWIDTH];
         off_q  <= status_addr[4:0];
         rd_q   <= status_read;
         wr_q   <= status_write;
         wdat_q <= status_writedata;
      end
   end

   logic hit;
   logic wr_vld;
   logic rd_vld;
   logic ctrl_wr;
   logic push_vld;
   logic push_rdy;
   logic clr_cnt;
   logic clr_stg;

   // A simultaneous read and write keeps only the write.
   assign hit      = (sel_q == SEL_VALUE);
   assign wr_vld   = hit & wr_q;
   assign rd_vld   = hit & rd_q & ~wr_q;
   assign ctrl_wr  = wr_vld & (off_q == 5'd16);
   assign push_vld = ctrl_wr & wdat_q[0];
   assign clr_cnt  = ctrl_wr & wdat_q[1];
   assign clr_stg  = ctrl_wr & wdat_q[2];

   logic [511:0] stg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg <= '0;
      end else if (clr_stg) begin
         stg <= '0;
      end else if (wr_vld && !off_q[4]) begin
         stg[{off_q[3:0], 5'b0} +: 32] <= wdat_q;
      end
   end

   logic [LVL_W-1:0] level;
   logic             full;
   logic             empty;

   // The FIFO samples the pre-clear staging beat, so PUSH with CLR_STG enqueues the old contents.
   ruleid_fifo #(
      .W     (512),
      .DEPTH (FIFO_DEPTH),
      .LW    (LVL_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld),
      .push_dat (stg),
      .push_rdy (push_rdy),
      .pop_rdy  (out_ready),
      .head_vld (out_valid),
      .head_dat (out_data),
      .level    (level),
      .full     (full),
      .empty    (empty)
   );

   logic [31:0] sent;
   logic [15:0] drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sent <= '0;
         drop <= '0;
      end else if (clr_cnt) begin
         sent <= '0;
         drop <= '0;
      end else begin
         if (out_valid && out_ready) sent <= sent + 32'd1;
         if (push_vld && !push_rdy && drop != 16'hFFFF) drop <= drop + 16'd1;
      end
   end

   logic [31:0] lvl_ext;
   logic        lvl_unused;
   logic [31:0] rd_mux;

   assign lvl_ext    = 32'(level);
   assign lvl_unused = ^lvl_ext[31:4];

   always_comb begin
      rd_mux = '0;
      if (!off_q[4]) begin
         rd_mux = stg[{off_q[3:0], 5'b0} +: 32];
      end else begin
         case (off_q[3:0])
            4'd1:    rd_mux = {26'b0, full, empty, lvl_ext[3:0]};
            4'd2:    rd_mux = sent;
            4'd3:    rd_mux = {16'b0, drop};
            default: rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_readdata       <= '0;
         status_readdata_valid <= 1'b0;
      end else begin
         status_readdata_valid <= rd_vld;
         if (rd_vld) status_readdata <= rd_mux;
      end
   end
endmodule

// File: tb/tb_ruleid_loader.sv
// Bench for ruleid_loader: queue-based reference model checked every cycle, plus directed literal checks.
module tb_ruleid_loader;
   localparam int         D   = 4;
   localparam logic [3:0] SEL = 4'd9;

   logic         clk = 1'b0;
   logic         rst;
   logic [29:0]  status_addr;
   logic         status_read;
   logic         status_write;
   logic [31:0]  status_writedata;
   logic [31:0]  status_readdata;
   logic         status_readdata_valid;
   logic [511:0] out_data;
   logic         out_valid;
   logic         out_ready;

   always #5 clk = ~clk;

   ruleid_loader #(
      .STAT_AWIDTH (4),
      .SEL_VALUE   (SEL),
      .FIFO_DEPTH  (D)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .status_addr           (status_addr),
      .status_read           (status_read),
      .status_write          (status_write),
      .status_writedata      (status_writedata),
      .status_readdata       (status_readdata),
      .status_readdata_valid (status_readdata_valid),
      .out_data              (out_data),
      .out_valid             (out_valid),
      .out_ready             (out_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: beat queue, staging words, counters, one-deep request pipe
   logic [511:0] mq[$];
   logic [511:0] got[$];
   logic [31:0]  m_stg[16];
   logic [31:0]  m_sent;
   int           m_drop;
   logic         m_rvld;
   logic [31:0]  m_rdata;
   logic         p_sel, p_rd, p_wr;
   int           p_off;
   logic [31:0]  p_dat;

   function automatic logic [511:0] stg_beat();
      logic [511:0] b;
      for (int k = 0; k < 16; k++) b[32*k +: 32] = m_stg[k];
      return b;
   endfunction

   function automatic logic [31:0] read_val(input int off, input int pre);
      if (off < 16)  return m_stg[off];
      if (off == 17) return {26'b0, pre == D, pre == 0, 4'(pre)};
      if (off == 18) return m_sent;
      if (off == 19) return {16'b0, 16'(m_drop)};
      return 32'h0;
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int k = 0; k < 16; k++) m_stg[k] = '0;
      m_sent = '0; m_drop = 0; m_rvld = 1'b0; m_rdata = '0;
      p_sel = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_off = 0; p_dat = '0;
   endtask

   task automatic model_step();
      int           pre;
      bit           pop, push, clr_c, clr_s;
      logic [511:0] beat;
      pre   = mq.size();
      pop   = (pre > 0) && out_ready;
      push  = 0; clr_c = 0; clr_s = 0;
      beat  = stg_beat();
      m_rvld = p_sel && p_rd && !p_wr;
      if (m_rvld) m_rdata = read_val(p_off, pre);
      if (p_sel && p_wr) begin
         if (p_off < 16) m_stg[p_off] = p_dat;
         else if (p_off == 16) begin
            push = p_dat[0]; clr_c = p_dat[1]; clr_s = p_dat[2];
         end
      end
      if (pop) begin
         void'(mq.pop_front());
         m_sent = m_sent + 32'd1;
      end
      if (push) begin
         if (pre < D || pop) mq.push_back(beat);
         else if (m_drop < 65535) m_drop++;
      end
      if (clr_c) begin m_sent = '0; m_drop = 0; end
      if (clr_s) for (int k = 0; k < 16; k++) m_stg[k] = '0;
      p_sel = (status_addr[29:26] == SEL);
      p_off = int'(status_addr[4:0]);
      p_rd  = status_read;
      p_wr  = status_write;
      p_dat = status_writedata;
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst) model_reset();
         chk("out_valid", out_valid, mq.size() != 0);
         if (mq.size() != 0) chk("out_data", out_data, mq[0]);
         chk("rd_valid", status_readdata_valid, m_rvld);
         chk("rd_data", status_readdata, m_rdata);
         if (out_valid && out_ready) got.push_back(out_data);
         if (rst) model_step();
      end
   end

   // Stimulus: entered and left at posedge+1
   task automatic bus(input bit rd, input bit wr, input logic [4:0] off, input logic [31:0] d,
                      input logic [3:0] sel);
      status_addr = {sel, 21'h1ABCD, off};
      status_read = rd; status_write = wr; status_writedata = d;
      @(posedge clk); #1;
      status_read = 1'b0; status_write = 1'b0;
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d);
      bus(1'b0, 1'b1, off, d, SEL);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic count_pulses(output int cnt, output int first, output logic [31:0] data);
      cnt = 0; first = -1; data = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (status_readdata_valid) begin
            cnt++;
            if (first < 0) begin first = i; data = status_readdata; end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic rd_chk(input logic [4:0] off, input logic [31:0] exp, input string name);
      int cnt, first;
      logic [31:0] data;
      bus(1'b1, 1'b0, off, 32'h0, SEL);
      count_pulses(cnt, first, data);
      chk({name, "_pulses"}, cnt, 1);
      chk({name, "_lat"}, first, 1);
      chk(name, data, exp);
   endtask

   task automatic beat_word(input int idx, input int k, input logic [31:0] exp, input string name);
      logic [511:0] b;
      if (idx < got.size()) begin
         b = got[idx];
         chk(name, b[32*k +: 32], exp);
      end else begin
         chk({name, "_present"}, got.size(), idx + 1);
      end
   endtask

   initial begin
      int cnt, first;
      logic [31:0] data;
      rst = 1'b0; status_addr = '0; status_read = 1'b0; status_write = 1'b0;
      status_writedata = '0; out_ready = 1'b0;
      idle(3);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_rd_valid", status_readdata_valid, 0);
      chk("reset_rd_data", status_readdata, 0);
      rst = 1'b1;
      idle(1);

      // Full beat assembled from 16 words
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) wr(5'(k), 32'h1000_0000 + 32'(k));
      wr(16, 32'h1);
      idle(4);
      chk("t1_beats", got.size(), 1);
      beat_word(0, 0, 32'h1000_0000, "t1_w0");
      beat_word(0, 7, 32'h1000_0007, "t1_w7");
      beat_word(0, 15, 32'h1000_000F, "t1_w15");
      rd_chk(18, 32'd1, "t1_sent");

      // Overfill with output stalled, then drain
      out_ready = 1'b0;
      wr(16, 32'h2);
      for (int i = 0; i < 5; i++) begin
         wr(0, 32'hA0 + 32'(i));
         wr(16, 32'h1);
      end
      rd_chk(17, 32'h24, "t2_status_full");
      rd_chk(19, 32'd1, "t2_drop");
      out_ready = 1'b1;
      idle(8);
      chk("t2_beats", got.size(), 5);
      for (int i = 0; i < 4; i++) beat_word(1 + i, 0, 32'hA0 + 32'(i), "t2_order");
      rd_chk(18, 32'd4, "t2_sent");
      rd_chk(17, 32'h10, "t2_status_empty");

      // Push into a full FIFO while it pops
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr(0, 32'hB0 + 32'(i));
         wr(16, 32'h1);
      end
      wr(0, 32'hB4);
      wr(16, 32'h1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      rd_chk(17, 32'h24, "t3_status_full");
      rd_chk(19, 32'd1, "t3_drop");
      out_ready = 1'b1;
      idle(8);
      chk("t3_beats", got.size(), 10);
      beat_word(5, 0, 32'hB0, "t3_first");
      beat_word(9, 0, 32'hB4, "t3_last");

      // Register access corner cases
      wr(3, 32'hDEAD_BEEF);
      rd_chk(3, 32'hDEAD_BEEF, "t4_raw");
      bus(1'b1, 1'b0, 3, 32'h0, 4'd8);
      count_pulses(cnt, first, data);
      chk("t4_unsel_pulses", cnt, 0);
      rd_chk(25, 32'h0, "t4_off25");
      rd_chk(16, 32'h0, "t4_ctrl_rd");
      wr(18, 32'h55);
      rd_chk(18, 32'd9, "t4_ro_sent");
      bus(1'b1, 1'b1, 3, 32'h1234_5678, SEL);
      count_pulses(cnt, first, data);
      chk("t4_rw_pulses", cnt, 0);
      rd_chk(3, 32'h1234_5678, "t4_rw_word");

      // PUSH + CLR_CNT + CLR_STG together
      out_ready = 1'b0;
      wr(16, 32'h7);
      rd_chk(18, 32'd0, "t5_sent");
      rd_chk(19, 32'd0, "t5_drop");
      rd_chk(3, 32'h0, "t5_w3");
      rd_chk(5, 32'h0, "t5_w5");
      rd_chk(17, 32'h01, "t5_status");
      out_ready = 1'b1;
      idle(4);
      chk("t5_beats", got.size(), 11);
      beat_word(10, 0, 32'hB4, "t5_w0");
      beat_word(10, 3, 32'h1234_5678, "t5_w3");
      beat_word(10, 5, 32'h1000_0005, "t5_w5");
      rd_chk(18, 32'd1, "t5_sent_after");

      // Reset with queued beats and a read in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr(0, 32'hC0 + 32'(i));
         wr(16, 32'h1);
      end
      bus(1'b1, 1'b0, 18, 32'h0, SEL);
      rst = 1'b0;
      #1;
      chk("t6_valid_drop", out_valid, 0);
      idle(2);
      rst = 1'b1;
      count_pulses(cnt, first, data);
      chk("t6_no_pulse", cnt, 0);
      rd_chk(17, 32'h10, "t6_status");
      rd_chk(0, 32'h0, "t6_stg");
      chk("t6_beats", got.size(), 11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
